buffered_uart: RTL

Full-duplex UART port with runtime-configurable bit period, data length, parity and stop bits, and a FIFO on each direction. It is the next-generation replacement for the fixed-8N1, unbuffered UART wrapper and sits between a bus-facing peripheral register block and the chip-level `rx`/`tx` pads. The register block writes transmit bytes into the TX FIFO, pops received bytes with their error flags from the RX FIFO, and polls the sticky error status.

---
 rtl/buffered_uart.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/buffered_uart.sv
// Full-duplex UART with runtime frame format and a FIFO on each direction.
// Both serial engines latch their configuration at frame start.
module buffered_uart #(
  parameter int unsigned CLOCK_SCALE_BITS = 16,
  parameter int unsigned FIFO_DEPTH_LOG2  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic [1:0]                  dataBits,
  input  logic [1:0]                  parityMode,
  input  logic                        twoStopBits,
  input  logic                        txWriteEnable,
  input  logic [7:0]                  txData,
  output logic                        txFull,
  output logic                        txBusy,
  output logic [FIFO_DEPTH_LOG2:0]    txCount,
  input  logic                        rxReadEnable,
  output logic                        rxDataAvailable,
  output logic [7:0]                  rxData,
  output logic                        rxParityError,
  output logic                        rxFrameError,
  output logic [FIFO_DEPTH_LOG2:0]    rxCount,
  output logic                        rxOverflow,
  input  logic                        clearErrors,
  input  logic                        rx,
  output logic                        tx
);
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic [7:0]                 tx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] tx_wr, tx_rd;
  logic                       tx_pop, tx_push, tx_empty;
  logic [7:0]                 tx_head, tx_masked;

  assign tx_empty = (txCount == '0);
  assign txFull   = txCount[FIFO_DEPTH_LOG2];
  assign tx_push  = txWriteEnable && (!txFull || tx_pop);
  assign tx_head  = tx_mem[tx_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr   <= '0;
      tx_rd   <= '0;
      txCount <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      txCount <= txCount + 1'b1;
      else if (!tx_push && tx_pop) txCount <= txCount - 1'b1;
    end
  end

  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wr] <= txData;

  tx_state_t                   tx_state, tx_state_n;
  logic [CLOCK_SCALE_BITS-1:0] tx_timer, tx_timer_n, tx_cpb, tx_cpb_n;
  logic [2:0]                  tx_idx, tx_idx_n, tx_last, tx_last_n;
  logic [7:0]                  tx_sh, tx_sh_n;
  logic                        tx_par, tx_par_n, tx_par_en, tx_par_en_n, tx_two, tx_two_n;
  logic                        tx_n, tx_bit_end, tx_free;

  assign tx_masked = tx_head & (8'hFF >> (2'd3 - dataBits));
  assign txBusy    = !tx_empty || (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= TX_IDLE;
      tx_timer  <= '0;
      tx_cpb    <= '0;
      tx_idx    <= '0;
      tx_last   <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
      tx_two    <= 1'b0;
      tx        <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_timer  <= tx_timer_n;
      tx_cpb    <= tx_cpb_n;
      tx_idx    <= tx_idx_n;
      tx_last   <= tx_last_n;
      tx_sh     <= tx_sh_n;
      tx_par    <= tx_par_n;
      tx_par_en <= tx_par_en_n;
      tx_two    <= tx_two_n;
      tx        <= tx_n;
    end
  end

  // tx is registered from the next state, so the line changes on the same edge as the state.
  always_comb begin
    tx_state_n  = tx_state;
    tx_timer_n  = tx_timer + 1'b1;
    tx_cpb_n    = tx_cpb;
    tx_idx_n    = tx_idx;
    tx_last_n   = tx_last;
    tx_sh_n     = tx_sh;
    tx_par_n    = tx_par;
    tx_par_en_n = tx_par_en;
    tx_two_n    = tx_two;
    tx_n        = tx;
    tx_pop      = 1'b0;
    tx_bit_end  = (tx_timer == tx_cpb);
    case (tx_state)
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_timer_n = '0;
        tx_idx_n   = '0;
        tx_n       = tx_sh[0];
      end
      TX_DATA: if (tx_bit_end) begin
        tx_timer_n = '0;
        if (tx_idx == tx_last) begin
          tx_state_n = tx_par_en ? TX_PARITY : TX_STOP1;
          tx_n       = tx_par_en ? tx_par : 1'b1;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
          tx_sh_n  = tx_sh >> 1;
          tx_n     = tx_sh[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_n = TX_STOP1;
        tx_timer_n = '0;
        tx_n       = 1'b1;
      end
      TX_STOP1: if (tx_bit_end && tx_two) begin
        tx_state_n = TX_STOP2;
        tx_timer_n = '0;
      end
      default: ;
    endcase
    // Loading straight from the end of the last stop bit keeps back-to-back frames gapless.
    tx_free = (tx_state == TX_IDLE) ||
              (tx_bit_end && ((tx_state == TX_STOP2) || (tx_state == TX_STOP1 && !tx_two)));
    if (tx_free) begin
      tx_state_n = TX_IDLE;
      tx_timer_n = '0;
      tx_n       = 1'b1;
      if (!tx_empty) begin
        tx_pop      = 1'b1;
        tx_state_n  = TX_START;
        tx_n        = 1'b0;
        tx_cpb_n    = cyclesPerBit;
        tx_last_n   = 3'(dataBits) + 3'd4;
        tx_sh_n     = tx_masked;
        tx_par_en_n = ^parityMode;
        tx_par_n    = (^tx_masked) ^ parityMode[1];
        tx_two_n    = twoStopBits;
      end
    end
  end

  logic [9:0]                 rx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rx_wr, rx_rd;
  logic                       rx_push, rx_pop, rx_store, rx_full, rx_empty;
  logic [9:0]                 rx_entry, rx_head;

  assign rx_empty        = (rxCount == '0);
  assign rx_full         = rxCount[FIFO_DEPTH_LOG2];
  assign rx_pop          = rxReadEnable && !rx_empty;
  assign rx_store        = rx_push && (!rx_full || rx_pop);
  assign rx_head         = rx_empty ? '0 : rx_mem[rx_rd];
  assign rxDataAvailable = !rx_empty;
  assign {rxParityError, rxFrameError, rxData} = rx_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rxCount    <= '0;
      rxOverflow <= 1'b0;
    end else begin
      if (rx_store) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
      if (rx_store && !rx_pop)      rxCount <= rxCount + 1'b1;
      else if (!rx_store && rx_pop) rxCount <= rxCount - 1'b1;
      if (rx_push && !rx_store) rxOverflow <= 1'b1;
      else if (clearErrors)     rxOverflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) if (rx_store) rx_mem[rx_wr] <= rx_entry;

  rx_state_t                   rx_state, rx_state_n;
  logic [CLOCK_SCALE_BITS-1:0] rx_timer, rx_timer_n, rx_cpb, rx_cpb_n;
  logic [2:0]                  rx_idx, rx_idx_n, rx_last, rx_last_n;
  logic [7:0]                  rx_sh, rx_sh_n;
  logic                        rx_acc, rx_acc_n, rx_par_en, rx_par_en_n, rx_odd, rx_odd_n;
  logic                        rx_meta, rx_s, rx_prev, rx_sample;

  assign rx_entry = {rx_par_en && (rx_acc != rx_odd), ~rx_s, rx_sh};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_timer  <= '0;
      rx_cpb    <= '0;
      rx_idx    <= '0;
      rx_last   <= '0;
      rx_sh     <= '0;
      rx_acc    <= 1'b0;
      rx_par_en <= 1'b0;
      rx_odd    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      rx_state  <= rx_state_n;
      rx_timer  <= rx_timer_n;
      rx_cpb    <= rx_cpb_n;
      rx_idx    <= rx_idx_n;
      rx_last   <= rx_last_n;
      rx_sh     <= rx_sh_n;
      rx_acc    <= rx_acc_n;
      rx_par_en <= rx_par_en_n;
      rx_odd    <= rx_odd_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_timer_n  = rx_timer + 1'b1;
    rx_cpb_n    = rx_cpb;
    rx_idx_n    = rx_idx;
    rx_last_n   = rx_last;
    rx_sh_n     = rx_sh;
    rx_acc_n    = rx_acc;
    rx_par_en_n = rx_par_en;
    rx_odd_n    = rx_odd;
    rx_push     = 1'b0;
    rx_sample   = (rx_timer == rx_cpb);
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_state_n  = RX_START;
        rx_timer_n  = '0;
        rx_cpb_n    = cyclesPerBit;
        rx_last_n   = 3'(dataBits) + 3'd4;
        rx_par_en_n = ^parityMode;
        rx_odd_n    = parityMode[1];
        rx_sh_n     = '0;
        rx_acc_n    = 1'b0;
      end
      RX_START: if (rx_timer == (rx_cpb >> 1)) begin
        rx_timer_n = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_timer_n      = '0;
        rx_sh_n[rx_idx] = rx_s;
        rx_acc_n        = rx_acc ^ rx_s;
        if (rx_idx == rx_last) rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
        else                   rx_idx_n   = rx_idx + 1'b1;
      end
      RX_PARITY: if (rx_sample) begin
        rx_timer_n = '0;
        rx_acc_n   = rx_acc ^ rx_s;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_push    = 1'b1;
        rx_state_n = RX_IDLE;
      end
      default: ;
    endcase
  end
endmodule
